// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uarttx handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic                 err_timeout;
  logic                 send;
  logic [7:0]           dintx;
  logic                 donetx;

  // master: clients plus the uarttx done flag; slave: the arbiter
  modport master (
    output req, req_data, donetx,
    input  ack, busy, grant_id, err_timeout, send, dintx
  );
  modport slave (
    input  req, req_data, donetx,
    output ack, busy, grant_id, err_timeout, send, dintx
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uarttx between NUM_REQ byte requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_CLR} state_t;

  state_t             state, state_nx;
  logic [IDW-1:0]     rr, rr_nx;
  logic [IDW-1:0]     grant_id, grant_id_nx;
  logic [IDW-1:0]     sel_idx;
  logic               sel_found;
  logic [IDW:0]       scan;
  logic [7:0]         sel_data;
  logic [7:0]         dintx, dintx_nx;
  logic               send, send_nx;
  logic               busy, busy_nx;
  logic               err, err_nx;
  logic [NUM_REQ-1:0] ack, ack_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic               donetx_q;
  logic               rise;

  assign rise = bus.donetx & ~donetx_q;

  // Scan downward so the requester closest to rr is written last and wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NUM_REQ))
        scan = scan - (IDW+1)'(NUM_REQ);
      if (bus.req[scan[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel_idx == IDW'(i))
        sel_data = bus.req_data[8*i +: 8];
  end

  always_comb begin
    state_nx    = state;
    rr_nx       = rr;
    grant_id_nx = grant_id;
    dintx_nx    = dintx;
    send_nx     = send;
    busy_nx     = busy;
    cnt_nx      = cnt;
    ack_nx      = '0;
    err_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_id_nx = sel_idx;
          dintx_nx    = sel_data;
          busy_nx     = 1'b1;
          send_nx     = 1'b1;
          cnt_nx      = '0;
          state_nx    = SEND;
        end
      end
      SEND: begin
        cnt_nx = cnt + CW'(1);
        // A rise on the timeout cycle still counts as a completed byte.
        if (rise || cnt == CNT_LAST) begin
          send_nx  = 1'b0;
          ack_nx   = NUM_REQ'(1) << grant_id;
          err_nx   = ~rise;
          rr_nx    = (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
          state_nx = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (!bus.donetx) begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr       <= '0;
      grant_id <= '0;
      dintx    <= 8'h00;
      send     <= 1'b0;
      busy     <= 1'b0;
      ack      <= '0;
      err      <= 1'b0;
      cnt      <= '0;
      donetx_q <= 1'b0;
    end else begin
      state    <= state_nx;
      rr       <= rr_nx;
      grant_id <= grant_id_nx;
      dintx    <= dintx_nx;
      send     <= send_nx;
      busy     <= busy_nx;
      ack      <= ack_nx;
      err      <= err_nx;
      cnt      <= cnt_nx;
      donetx_q <= bus.donetx;
    end
  end

  assign bus.ack         = ack;
  assign bus.busy        = busy;
  assign bus.grant_id    = grant_id;
  assign bus.err_timeout = err;
  assign bus.send        = send;
  assign bus.dintx       = dintx;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 100;
  localparam int NTXN = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_en = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         gcyc;
    int         lat;
    bit         to;
  } exp_t;

  typedef struct {
    int   at;
    logic val;
  } ev_t;

  exp_t exp_q[$];
  ev_t  ev_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
  endtask

  task automatic push_ev(input int at, input logic val);
    ev_t ev;
    ev.at  = at;
    ev.val = val;
    ev_q.push_back(ev);
  endtask

  task automatic apply_events();
    while (ev_q.size() > 0 && ev_q[0].at <= cyc) begin
      bus.donetx = ev_q[0].val;
      void'(ev_q.pop_front());
    end
  endtask

  initial begin : monitor
    logic send_q;
    exp_t e;
    send_q = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.send && !send_q) begin
          if (exp_q.size() == 0) begin
            check("grant_unexpected", 32'(bus.send), 32'd0);
          end else begin
            e = exp_q[0];
            check("grant_cycle", 32'(cyc), 32'(e.gcyc));
            check("grant_id", 32'(bus.grant_id), 32'(e.id));
            check("grant_data", 32'(bus.dintx), 32'(e.data));
          end
        end
        if (bus.ack != '0 || bus.err_timeout) begin
          if (exp_q.size() == 0) begin
            check("ack_unexpected", 32'({bus.ack, bus.err_timeout}), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ack_onehot", 32'(bus.ack), 32'(1) << e.id);
            check("err_timeout", 32'(bus.err_timeout), 32'(e.to));
            check("ack_cycle", 32'(cyc), 32'(e.gcyc + e.lat));
            check("dintx_held", 32'(bus.dintx), 32'(e.data));
            check("send_low_at_ack", 32'(bus.send), 32'd0);
          end
        end
      end
      send_q = bus.send;
    end
  end

  initial begin : stim
    bit               pend [NREQ];
    logic [7:0]       pdata [NREQ];
    int               mrr, win, txn, guard, cur_id, mode, d, h, l, w, g;
    logic [NREQ-1:0]  newm;
    logic [NREQ-1:0]  ack_or;
    logic             busy_or;
    exp_t             e;

    // Directed: reset, single grant, rr after reset.
    bus.req      = '0;
    bus.req_data = '0;
    bus.donetx   = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus.send, bus.busy, bus.ack, bus.grant_id, bus.err_timeout, bus.dintx}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.req_data[23:16] = 8'hA5;
    bus.req             = 4'b0100;
    @(negedge clk);
    check("d_grant_send_busy", 32'({bus.send, bus.busy}), 32'h3);
    check("d_grant_id", 32'(bus.grant_id), 32'd2);
    check("d_grant_data", 32'(bus.dintx), 32'hA5);
    bus.req_data[23:16] = 8'h00;
    repeat (50) @(negedge clk);
    check("d_send_held", 32'({bus.send, bus.dintx}), 32'h1A5);
    bus.donetx = 1'b1;
    @(negedge clk);
    check("d_ack", 32'({bus.ack, bus.send, bus.err_timeout}), 32'h10);
    bus.req = '0;
    @(negedge clk);
    check("d_wait_clr", 32'({bus.ack, bus.busy}), 32'h1);
    bus.donetx = 1'b0;
    @(negedge clk);
    check("d_busy_fall", 32'(bus.busy), 32'd0);
    bus.req_data[31:24] = 8'h5A;
    bus.req_data[7:0]   = 8'h11;
    bus.req             = 4'b1001;
    @(negedge clk);
    check("d_rr_next", 32'(bus.grant_id), 32'd3);
    repeat (3) @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    check("d_mid_reset", 32'({bus.send, bus.busy, bus.ack, bus.grant_id, bus.err_timeout, bus.dintx}), 32'd0);
    ack_or     = '0;
    busy_or    = 1'b0;
    bus.donetx = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ack_or  = ack_or | bus.ack;
      busy_or = busy_or | bus.busy;
      if (i == 2) bus.donetx = 1'b0;
    end
    check("d_no_ack_after_reset", 32'({ack_or, busy_or}), 32'd0);
    bus.req = 4'b1001;
    @(negedge clk);
    check("d_rr_reset_gid", 32'(bus.grant_id), 32'd0);
    check("d_rr_reset_data", 32'(bus.dintx), 32'h11);
    bus.donetx = 1'b1;
    @(negedge clk);
    check("d_ack0", 32'(bus.ack), 32'h1);
    bus.req    = '0;
    bus.donetx = 1'b0;
    repeat (2) @(negedge clk);
    check("d_idle", 32'(bus.busy), 32'd0);

    // Randomized phase: model holds pending set, data and rr pointer.
    for (int i = 0; i < NREQ; i++) begin
      pend[i]  = 1'b0;
      pdata[i] = 8'h00;
    end
    mrr    = 1;
    cur_id = -1;
    txn    = 0;
    guard  = 0;
    mon_en = 1'b1;
    while (txn < NTXN && guard < 20000) begin
      @(negedge clk);
      guard++;
      apply_events();
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i] && pend[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            pdata[i] = 8'($urandom);
            bus.req_data[8*i +: 8] = pdata[i];
          end else begin
            pend[i]    = 1'b0;
            bus.req[i] = 1'b0;
          end
        end
      end
      if (bus.busy) begin
        if ($urandom_range(0, 7) == 0) begin
          g = $urandom_range(0, NREQ - 1);
          if (pend[g]) begin
            pdata[g] = 8'($urandom);
            bus.req_data[8*g +: 8] = pdata[g];
          end
        end
        if (cur_id >= 0 && bus.send && pend[cur_id] && $urandom_range(0, 15) == 0) begin
          pend[cur_id]    = 1'b0;
          bus.req[cur_id] = 1'b0;
        end
      end else begin
        newm = NREQ'($urandom);
        for (int i = 0; i < NREQ; i++) begin
          if (newm[i] && !pend[i]) begin
            pend[i]  = 1'b1;
            pdata[i] = 8'($urandom);
            bus.req_data[8*i +: 8] = pdata[i];
            bus.req[i] = 1'b1;
          end
        end
        win = -1;
        for (int k = 0; k < NREQ; k++)
          if (win < 0 && pend[(mrr + k) % NREQ]) win = (mrr + k) % NREQ;
        if (win < 0) begin
          win        = $urandom_range(0, NREQ - 1);
          pend[win]  = 1'b1;
          pdata[win] = 8'($urandom);
          bus.req_data[8*win +: 8] = pdata[win];
          bus.req[win] = 1'b1;
        end
        mrr    = (win + 1) % NREQ;
        g      = cyc + 1;
        e.id   = win;
        e.data = pdata[win];
        e.gcyc = g;
        e.to   = 1'b0;
        mode   = $urandom_range(0, 9);
        w      = $urandom_range(1, 4);
        if (mode < 2) begin
          e.lat = TMO;
          e.to  = 1'b1;
        end else if (mode < 4) begin
          h = $urandom_range(1, 30);
          l = $urandom_range(1, 30);
          bus.donetx = 1'b1;
          push_ev(g + h, 1'b0);
          push_ev(g + h + l, 1'b1);
          push_ev(g + h + l + w, 1'b0);
          e.lat = h + l + 1;
        end else begin
          if (mode == 4) d = TMO - 1 + $urandom_range(0, 1);
          else d = $urandom_range(0, 80);
          push_ev(g + d, 1'b1);
          push_ev(g + d + w, 1'b0);
          e.to  = (d + 1 > TMO);
          e.lat = e.to ? TMO : d + 1;
        end
        exp_q.push_back(e);
        cur_id = win;
        txn++;
      end
    end
    check("txn_issued", 32'(txn), 32'(NTXN));

    @(negedge clk);
    apply_events();
    bus.req = '0;
    guard   = 0;
    while ((exp_q.size() > 0 || bus.busy) && guard < 2000) begin
      @(negedge clk);
      apply_events();
      guard++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("arbiter_idle", 32'({bus.busy, bus.send}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
